// File: rtl/soc_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM states, command codes and
// default framing / acknowledge constants.
package soc_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_ACK,
    ST_RUN
  } state_t;

  localparam logic [7:0]  CMD_WRITE          = 8'h01;
  localparam logic [7:0]  CMD_GO             = 8'h02;
  localparam logic [7:0]  DEF_SYNC_BYTE      = 8'hA5;
  localparam logic [7:0]  DEF_ACK_OK         = 8'h06;
  localparam logic [7:0]  DEF_ACK_ERR        = 8'h15;
  localparam logic [3:0]  DEF_RAM_NIBBLE     = 4'h8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;

  function automatic logic in_ram_window(input logic [31:0] addr,
                                         input logic [3:0]  nibble);
    return addr[31:28] == nibble;
  endfunction

endpackage

// File: rtl/uart_boot_loader.sv
// Byte-stream boot loader: parses WRITE/GO frames from the UART RX side,
// writes little-endian words into RAM while holding the CPU, then releases it.
module uart_boot_loader
  import soc_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter logic [7:0]  ACK_OK         = DEF_ACK_OK,
  parameter logic [7:0]  ACK_ERR        = DEF_ACK_ERR,
  parameter logic [3:0]  RAM_NIBBLE     = DEF_RAM_NIBBLE,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        cpu_hold,
  output logic        busy,
  output logic        err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t       state, next_state;
  logic [1:0]   byte_cnt;
  logic [31:0]  addr;
  logic [23:0]  word_buf;
  logic [7:0]   len_lo;
  logic [15:0]  word_cnt;
  logic [7:0]   csum;
  logic         frame_bad;
  logic         is_go;
  logic         ack_go;
  logic [TW-1:0] tcnt;

  logic active, timeout, csum_ok, err_set;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    active     = state inside {ST_CMD, ST_ADDR, ST_LEN, ST_DATA, ST_CSUM};
    timeout    = active && !rx_valid && (tcnt == T_LAST);
    csum_ok    = (rx_data == csum) && !frame_bad;
    err_set    = 1'b0;
    next_state = state;

    case (state)
      ST_IDLE: if (rx_valid && rx_data == SYNC_BYTE) next_state = ST_CMD;
      ST_CMD: if (rx_valid) begin
        if (rx_data == CMD_WRITE)   next_state = ST_ADDR;
        else if (rx_data == CMD_GO) next_state = ST_CSUM;
        else begin
          next_state = ST_IDLE;
          err_set    = 1'b1;
        end
      end
      ST_ADDR: if (rx_valid && byte_cnt == 2'd3) next_state = ST_LEN;
      ST_LEN: if (rx_valid && byte_cnt == 2'd1)
        next_state = ({rx_data, len_lo} == 16'd0) ? ST_CSUM : ST_DATA;
      ST_DATA: if (rx_valid && byte_cnt == 2'd3 && word_cnt == 16'd1)
        next_state = ST_CSUM;
      ST_CSUM: if (rx_valid) begin
        next_state = ST_ACK;
        err_set    = !csum_ok;
      end
      ST_ACK: if (tx_ready) next_state = ack_go ? ST_RUN : ST_IDLE;
      ST_RUN: next_state = ST_RUN;
      default: next_state = ST_IDLE;
    endcase

    // Silence between bytes abandons the frame without an acknowledge.
    if (timeout) begin
      next_state = ST_IDLE;
      err_set    = 1'b1;
    end
  end

  assign busy     = !(state inside {ST_IDLE, ST_RUN});
  assign cpu_hold = (state != ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      err       <= 1'b0;
      byte_cnt  <= '0;
      addr      <= '0;
      word_buf  <= '0;
      len_lo    <= '0;
      word_cnt  <= '0;
      csum      <= '0;
      frame_bad <= 1'b0;
      is_go     <= 1'b0;
      ack_go    <= 1'b0;
      tcnt      <= '0;
    end else begin
      mem_wstrb <= '0;
      tx_valid  <= (next_state == ST_ACK);
      tcnt      <= (!active || rx_valid) ? '0 : tcnt + 1'b1;
      if (err_set) err <= 1'b1;

      if (state == ST_IDLE && next_state == ST_CMD) begin
        csum      <= '0;
        frame_bad <= 1'b0;
        byte_cnt  <= '0;
      end else if (rx_valid) begin
        case (state)
          ST_CMD: begin
            csum     <= csum ^ rx_data;
            is_go    <= (rx_data == CMD_GO);
            byte_cnt <= '0;
          end
          ST_ADDR: begin
            csum     <= csum ^ rx_data;
            addr     <= (byte_cnt == 2'd3) ? {rx_data, addr[31:10], 2'b00}
                                           : {rx_data, addr[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
          end
          ST_LEN: begin
            csum <= csum ^ rx_data;
            if (byte_cnt == 2'd0) begin
              len_lo   <= rx_data;
              byte_cnt <= 2'd1;
            end else begin
              word_cnt <= {rx_data, len_lo};
              byte_cnt <= 2'd0;
            end
          end
          ST_DATA: begin
            csum     <= csum ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Out-of-window words are still consumed to keep the frame aligned.
              mem_addr  <= addr;
              mem_wdata <= {rx_data, word_buf};
              if (in_ram_window(addr, RAM_NIBBLE)) mem_wstrb <= 4'hF;
              else                                 frame_bad <= 1'b1;
              addr     <= addr + 32'd4;
              word_cnt <= word_cnt - 16'd1;
            end else begin
              word_buf <= {rx_data, word_buf[23:8]};
            end
          end
          ST_CSUM: begin
            tx_data <= csum_ok ? ACK_OK : ACK_ERR;
            ack_go  <= is_go && csum_ok;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
